// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game flow controller and the
// LED/LCD controllers that decode its state.
//   state_t          : FSM state codes (IDLE=0 .. PAUSE=4), 3 bits wide
//   STEP_MS_DEFAULT  : default number of 1 ms ticks per countdown step
//   STATE_W, CD_W    : widths of o_state and o_countdown
package game_pkg;

  localparam int STEP_MS_DEFAULT = 1000;
  localparam int STATE_W         = 3;
  localparam int CD_W            = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_RESULT    = 3'd3,
    ST_PAUSE     = 3'd4
  } state_t;

endpackage

// File: rtl/cd_step_timer.sv
// cd_step_timer -- countdown step/digit timer.
// Counts tick strobes; every STEP_MS ticks the digit decrements by one.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   tick     : count strobe (the parent gates it to COUNTDOWN)
//   load     : load digit with CD_STEPS, clear the step counter
//   clear    : zero digit and step counter (wins over load and tick)
//   digit    : registered remaining countdown digit
//   done     : combinational strobe, high in the clk whose tick takes the
//              digit from 1 to 0, so the parent can change state on the
//              same edge the digit reaches 0
module cd_step_timer
  import game_pkg::*;
#(
  parameter int STEP_MS  = STEP_MS_DEFAULT,
  parameter int CD_STEPS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            load,
  input  logic            clear,
  output logic [CD_W-1:0] digit,
  output logic            done
);

  localparam int              CNT_W    = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_MS - 1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(CD_STEPS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CD_W-1:0]  digit_q, digit_d;
  logic             counting;
  logic             step_wrap;

  // A zero digit means the countdown is over; further ticks are ignored.
  assign counting  = tick && (digit_q != '0);
  assign step_wrap = counting && (cnt_q == CNT_LAST);
  assign done      = step_wrap && (digit_q == CD_W'(1));
  assign digit     = digit_q;

  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (clear) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (load) begin
      cnt_d   = '0;
      digit_d = CD_INIT;
    end else if (step_wrap) begin
      cnt_d   = '0;
      digit_d = digit_q - CD_W'(1);
    end else if (counting) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl -- top-level game flow FSM: IDLE -> COUNTDOWN -> PLAY ->
// RESULT, restart from anywhere, optional PAUSE.
// Optional feature: define GAME_PAUSE_EN to enable PLAY <-> PAUSE on i_start.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_tick       : 1 ms strobe, one clk wide
//   i_start      : start-button pulse, one clk wide
//   i_restart    : restart-button pulse, one clk wide
//   i_game_end   : level, chart finished
//   o_state      : current state code (debug / LED / LCD decode)
//   o_game_run   : high only in PLAY
//   o_timer_clr  : one-clk game-timer clear pulse
//   o_round_clr  : one-clk round clear pulse (score, judgement, LCD)
//   o_siren_en   : high in IDLE and RESULT
//   o_countdown  : remaining countdown digit, 0 outside COUNTDOWN
// Interface semantics: there is no valid/ready handshake; inputs are
// single-clk strobes or levels sampled every clk, and every output is
// registered, changing one clk after the input that caused it.
// Same-clk priority: i_restart > i_game_end > i_start > i_tick.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int STEP_MS  = STEP_MS_DEFAULT,
  parameter int CD_STEPS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_restart,
  input  logic               i_game_end,
  output logic [STATE_W-1:0] o_state,
  output logic               o_game_run,
  output logic               o_timer_clr,
  output logic               o_round_clr,
  output logic               o_siren_en,
  output logic [CD_W-1:0]    o_countdown
);

  state_t state_q, state_d;
  logic   run_q, run_d;
  logic   tclr_q, tclr_d;
  logic   rclr_q, rclr_d;
  logic   siren_q, siren_d;

  logic   cd_tick, cd_load, cd_clear, cd_done;

  // Kept outside the FSM block so cd_done does not loop back into it.
  assign cd_tick = i_tick && (state_q == ST_COUNTDOWN);

  cd_step_timer #(
    .STEP_MS  (STEP_MS),
    .CD_STEPS (CD_STEPS)
  ) u_cd (
    .clk   (clk),
    .rst   (rst),
    .tick  (cd_tick),
    .load  (cd_load),
    .clear (cd_clear),
    .digit (o_countdown),
    .done  (cd_done)
  );

  always_comb begin
    state_d  = state_q;
    cd_load  = 1'b0;
    cd_clear = 1'b0;
    tclr_d   = 1'b0;
    rclr_d   = 1'b0;
    if (i_restart) begin
      state_d  = ST_IDLE;
      cd_clear = 1'b1;
      tclr_d   = 1'b1;
      rclr_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_COUNTDOWN;
            cd_load = 1'b1;
            tclr_d  = 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (cd_done) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (i_game_end) state_d = ST_RESULT;
`ifdef GAME_PAUSE_EN
          else if (i_start) state_d = ST_PAUSE;
`endif
        end
        ST_RESULT: begin
          state_d = ST_RESULT;
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSE: begin
          if (i_start) state_d = ST_PLAY;
        end
`endif
        default: begin
          // Unused codes (and PAUSE when the feature is absent) recover.
          state_d  = ST_IDLE;
          cd_clear = 1'b1;
        end
      endcase
    end
    // Level outputs are decoded from the next state so they are registered
    // yet change on the same edge as o_state.
    run_d   = (state_d == ST_PLAY);
    siren_d = (state_d == ST_IDLE) || (state_d == ST_RESULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      tclr_q  <= 1'b0;
      rclr_q  <= 1'b0;
      siren_q <= 1'b1;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tclr_q  <= tclr_d;
      rclr_q  <= rclr_d;
      siren_q <= siren_d;
    end
  end

  assign o_state     = state_q;
  assign o_game_run  = run_q;
  assign o_timer_clr = tclr_q;
  assign o_round_clr = rclr_q;
  assign o_siren_en  = siren_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl -- self-checking bench for game_flow_ctrl with
// STEP_MS=4, CD_STEPS=3. A behavioural model predicts the packed output
// vector {state, run, timer_clr, round_clr, siren, countdown} for each clk;
// the prediction is queued when the stimulus is driven and compared after
// the following rising edge.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int STEP = 4;
  localparam int CD   = 3;
  localparam int VW   = 9;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_tick = 1'b0, i_start = 1'b0, i_restart = 1'b0, i_game_end = 1'b0;
  logic [STATE_W-1:0] o_state;
  logic               o_game_run, o_timer_clr, o_round_clr, o_siren_en;
  logic [CD_W-1:0]    o_countdown;

  always #10 clk = ~clk;

  game_flow_ctrl #(.STEP_MS(STEP), .CD_STEPS(CD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (i_tick),
    .i_start     (i_start),
    .i_restart   (i_restart),
    .i_game_end  (i_game_end),
    .o_state     (o_state),
    .o_game_run  (o_game_run),
    .o_timer_clr (o_timer_clr),
    .o_round_clr (o_round_clr),
    .o_siren_en  (o_siren_en),
    .o_countdown (o_countdown)
  );

  logic [VW-1:0] obs_vec;
  assign obs_vec = {o_state, o_game_run, o_timer_clr, o_round_clr, o_siren_en, o_countdown};

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d run=%0b tclr=%0b rclr=%0b siren=%0b cd=%0d, expected st=%0d run=%0b tclr=%0b rclr=%0b siren=%0b cd=%0d",
               tag, got[8:6], got[5], got[4], got[3], got[2], got[1:0],
               exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state = 0;
  int m_cnt   = 0;
  int m_digit = 0;
  bit m_tclr  = 1'b0;
  bit m_rclr  = 1'b0;

  function automatic logic [VW-1:0] model_vec();
    logic [2:0] s;
    logic [1:0] d;
    s = 3'(m_state);
    d = 2'(m_digit);
    return {s, (m_state == 2), m_tclr, m_rclr, (m_state == 0 || m_state == 3), d};
  endfunction

  task automatic model_step(input bit st, input bit rs, input bit ge, input bit tk);
    m_tclr = 1'b0;
    m_rclr = 1'b0;
    if (rs) begin
      m_state = 0; m_cnt = 0; m_digit = 0; m_tclr = 1'b1; m_rclr = 1'b1;
    end else begin
      case (m_state)
        0: if (st) begin m_state = 1; m_digit = CD; m_cnt = 0; m_tclr = 1'b1; end
        1: if (tk) begin
             m_cnt++;
             if (m_cnt == STEP) begin
               m_cnt = 0;
               m_digit--;
               if (m_digit == 0) m_state = 2;
             end
           end
        2: if (ge) m_state = 3;
           else if (st && PAUSE_ON) m_state = 4;
        4: if (st) m_state = 2;
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input bit st, input bit rs, input bit ge, input bit tk);
    @(negedge clk);
    i_start = st; i_restart = rs; i_game_end = ge; i_tick = tk;
    model_step(st, rs, ge, tk);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    check_eq(tag, obs_vec, exp_q.pop_front());
  endtask

  // Asynchronous reset: outputs must reach reset values without a clk edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    i_start = 0; i_restart = 0; i_game_end = 0; i_tick = 0;
    rst = 1'b1;
    m_state = 0; m_cnt = 0; m_digit = 0; m_tclr = 1'b0; m_rclr = 1'b0;
    exp_q.push_back(model_vec());
    #1;
    check_eq(tag, obs_vec, exp_q.pop_front());
    @(posedge clk);
    #1;
    check_eq({tag, "_held"}, obs_vec, model_vec());
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs the countdown with irregular tick spacing until PLAY is reached.
  task automatic run_countdown(input string tag, input bit ge);
    for (int i = 0; i < 200 && m_state == 1; i++)
      step(tag, 1'b0, 1'b0, ge, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset("reset");
    for (int i = 0; i < 3; i++)
      step("idle", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Full countdown with a tick every clk: digits 3,2,1 at 4-tick spacing.
    step("start", 1'b1, 1'b0, 1'b0, 1'b0);
    step("cd_start_ignored", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CD * STEP; i++)
      step("cd_tick", 1'b0, 1'b0, 1'b0, 1'b1);
    step("play", 1'b0, 1'b0, 1'b0, 1'b1);

    // i_start in PLAY: pause toggle, or ignored without the feature.
    step("play_start", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef GAME_PAUSE_EN
    step("pause_ge_ignored", 1'b0, 1'b0, 1'b1, 1'b0);
    step("pause_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    step("unpause", 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    step("play_run", 1'b0, 1'b0, 1'b0, 1'b1);
    step("game_end", 1'b0, 1'b0, 1'b1, 1'b0);
    step("result_start_ignored", 1'b1, 1'b0, 1'b1, 1'b1);
    step("restart_from_result", 1'b0, 1'b1, 1'b0, 1'b0);
    step("idle_after_restart", 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart and game_end in the same PLAY clk: restart wins.
    step("start2", 1'b1, 1'b0, 1'b0, 1'b0);
    run_countdown("cd2", 1'b0);
    step("restart_ge", 1'b0, 1'b1, 1'b1, 1'b0);
    step("after_restart_ge", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while digit 2 is showing, then a clean restart from 3.
    step("start3", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && m_digit != 2; i++)
      step("cd3", 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step("cd3_mid", 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset("rst_mid_cd");
    step("restart_from3", 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart coinciding with a tick in COUNTDOWN.
    step("cd4", 1'b0, 1'b0, 1'b0, 1'b1);
    step("restart_cd_tick", 1'b0, 1'b1, 1'b0, 1'b1);

    // game_end held high through COUNTDOWN: RESULT on the clk after PLAY entry.
    step("start5", 1'b1, 1'b0, 1'b1, 1'b0);
    run_countdown("cd5_ge_held", 1'b1);
    step("ge_on_entry", 1'b0, 1'b0, 1'b1, 1'b0);
    step("result_stays", 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-PLAY.
    step("restart6", 1'b0, 1'b1, 1'b0, 1'b0);
    step("start6", 1'b1, 1'b0, 1'b0, 1'b0);
    run_countdown("cd6", 1'b0);
    step("play6", 1'b0, 1'b0, 1'b0, 1'b1);
    do_reset("rst_mid_play");

    // Random traffic with occasional buttons.
    for (int i = 0; i < 400; i++)
      step("random",
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
